matrix_writer: RTL and testbench
================================

Name: matrix_writer

Overview:
- Storage-side consumer of the input subsystem's matrix write handshake; sits directly downstream of it.
- Accepts one matrix descriptor (id, rows, cols, 8-byte name) per request.
- Streams element words into the owning slot of the matrix storage RAM, then commits the slot header last, so a partially written slot always reads as empty (header word 0 = 0).

Parameters:
- BLOCK_SIZE, 1152, words per matrix slot (3 header words + data).
- NUM_SLOTS, 8, number of matrix slots; valid matrix_id range is 0..NUM_SLOTS-1.
- DATA_WIDTH, 32, element and RAM word width.
- ADDR_WIDTH, 14, storage RAM address width; NUM_SLOTS*BLOCK_SIZE must be <= 2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- write_request  in  1  one-cycle descriptor strobe; sampled only in IDLE.
- write_ready  out  1  high only in IDLE; a request is accepted when write_request && write_ready.
- matrix_id  in  3  target slot.
- actual_rows  in  8  row count.
- actual_cols  in  8  column count.
- matrix_name  in  8x8 (unpacked [0:7])  name bytes; index 0 is the first character.
- data_in  in  DATA_WIDTH  element, row-major order.
- data_valid  in  1  element strobe; consumed only when writer_ready is high.
- writer_ready  out  1  high in DATA state while elements remain.
- write_done  out  1  one-cycle pulse after the header commit.
- write_error  out  1  one-cycle pulse on descriptor rejection.
- abort  in  1  cancels an in-progress write.
- mem_wr_en  out  1  storage RAM write enable.
- mem_wr_addr  out  ADDR_WIDTH  storage RAM write address.
- mem_wr_data  out  DATA_WIDTH  storage RAM write data.

Behaviour:
- Reset: all outputs 0 except write_ready=1; state=IDLE; counters and latched descriptor cleared. A reset mid-write abandons the operation. The slot is left with word0=0 if CLEAR has executed.
- Slot layout, base = id*BLOCK_SIZE:
  - word0 = {16'd0, rows, cols}
  - word1 = {name[0],name[1],name[2],name[3]}
  - word2 = {name[4],name[5],name[6],name[7]}
  - elements at base+3+k, k = 0..rows*cols-1.
- Base address is computed once at acceptance and held in a register.
- IDLE: on accepted request, latch id/rows/cols/name and go to CHECK. write_ready drops the next cycle.
- CHECK (1 cycle): reject if rows==0, cols==0, id>=NUM_SLOTS, or rows*cols > BLOCK_SIZE-3. The product is computed at 16 bits.
  - Reject: pulse write_error and return to IDLE. No RAM writes.
  - Accept: go to CLEAR.
- CLEAR (1 cycle): write 0 to base+0, invalidating the slot; go to DATA.
- DATA: writer_ready=1. Each data_valid writes data_in to base+3+k the same cycle (combinational mem_wr_* from registered state + input), then k++.
  - After element rows*cols-1 is written, go to NAME0; writer_ready is low from the next cycle.
  - Gaps in data_valid are allowed with no timeout.
  - data_valid outside DATA is ignored.
- NAME0 → NAME1 → HDR, one write each, then DONE.
- DONE: pulse write_done, return to IDLE.
- Latency: if the last element is written in cycle N, then word1 is written in N+1, word2 in N+2, word0 in N+3, and write_done is high in N+4.
- At most one mem_wr_en per cycle. Addresses never leave [base, base+BLOCK_SIZE-1].
- abort: in any non-IDLE state, go to IDLE next cycle. No write_done, no header commit; word0 stays 0 if CLEAR has run. In IDLE it is ignored.
- Simultaneous events:
  - abort and data_valid in the same DATA cycle: abort wins and no write occurs.
  - rst and anything: rst wins.
  - write_request outside IDLE: ignored, not queued.

Test Plan:
- Basic 2x2 write: id=1, 2x2, name "MAT_A\0\0\0", data 1,2,3,4 with 1-cycle gaps.
  - Writes 0@1152, then 1..4 at 1155..1158, then 0x4D41545F@1153, 0x41000000@1154, 0x00000202@1152.
  - write_done exactly 4 cycles after the element-4 write.
- Rejected descriptors:
  - rows=0, cols=3 → write_error pulse, no mem_wr_en, write_ready back to 1 two cycles after the request.
  - 34x34 (1156 > 1149) → write_error.
- Maximum size: id=7, 33x33 (1089 elements) → last data address 7*1152+3+1088=9155, then write_done.
- Abort: id=2, 3x3, abort after 5 elements.
  - No further writes; word0 at 2304 remains 0; no write_done.
  - A following 1x1 request to id=2 completes normally.
- Protocol robustness:
  - Extra data_valid after the last element → no write.
  - write_request during DATA → ignored.
  - rst during DATA → outputs at reset values next cycle.

Source files
------------

// File: rtl/matrix_writer_if.sv
// Matrix write handshake between the input subsystem and the storage writer,
// plus the storage RAM write port driven by the writer.
interface matrix_writer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 14
);
    logic                  write_request;
    logic                  write_ready;
    logic [2:0]            matrix_id;
    logic [7:0]            actual_rows;
    logic [7:0]            actual_cols;
    logic [7:0]            matrix_name [0:7];
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid;
    logic                  writer_ready;
    logic                  write_done;
    logic                  write_error;
    logic                  abort;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;

    modport master (
        output write_request, matrix_id, actual_rows, actual_cols, matrix_name,
        output data_in, data_valid, abort,
        input  write_ready, writer_ready, write_done, write_error,
        input  mem_wr_en, mem_wr_addr, mem_wr_data
    );

    modport slave (
        input  write_request, matrix_id, actual_rows, actual_cols, matrix_name,
        input  data_in, data_valid, abort,
        output write_ready, writer_ready, write_done, write_error,
        output mem_wr_en, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/matrix_writer.sv
// Writes one matrix into its storage slot: invalidates the header, streams the
// elements, then commits the name words and the header word last.
module matrix_writer #(
    parameter int unsigned BLOCK_SIZE = 1152,
    parameter int unsigned NUM_SLOTS  = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 14
) (
    input logic            clk,
    input logic            rst,
    matrix_writer_if.slave bus
);
    typedef enum logic [2:0] {
        StIdle, StCheck, StClear, StData, StName0, StName1, StHdr, StDone
    } state_e;

    localparam logic [15:0] MaxElems = 16'(BLOCK_SIZE - 3);

    state_e                state_q, state_d;
    logic [2:0]            id_q, id_d;
    logic [7:0]            rows_q, rows_d;
    logic [7:0]            cols_q, cols_d;
    logic [7:0]            name_q [8];
    logic [7:0]            name_d [8];
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  err_q, err_d;

    logic [15:0]           num_elems;
    logic                  reject;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    assign num_elems = 16'(rows_q) * 16'(cols_q);
    assign reject    = (rows_q == 8'd0) || (cols_q == 8'd0) ||
                       (32'(id_q) >= NUM_SLOTS) || (num_elems > MaxElems);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        rows_d  = rows_q;
        cols_d  = cols_q;
        name_d  = name_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = base_q;
        wr_data = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.write_request) begin
                    id_d    = bus.matrix_id;
                    rows_d  = bus.actual_rows;
                    cols_d  = bus.actual_cols;
                    name_d  = bus.matrix_name;
                    base_d  = ADDR_WIDTH'(32'(bus.matrix_id) * BLOCK_SIZE);
                    cnt_d   = '0;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (reject) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StClear;
                end
            end
            StClear: begin
                // Header word 0 goes to zero first so a partial slot reads as empty.
                wr_en   = 1'b1;
                state_d = StData;
            end
            StData: begin
                if (bus.data_valid) begin
                    wr_en   = 1'b1;
                    wr_addr = base_q + ADDR_WIDTH'(3) + ADDR_WIDTH'(cnt_q);
                    wr_data = bus.data_in;
                    cnt_d   = cnt_q + 16'd1;
                    if (cnt_q == num_elems - 16'd1) state_d = StName0;
                end
            end
            StName0: begin
                wr_en   = 1'b1;
                wr_addr = base_q + ADDR_WIDTH'(1);
                wr_data = DATA_WIDTH'({name_q[0], name_q[1], name_q[2], name_q[3]});
                state_d = StName1;
            end
            StName1: begin
                wr_en   = 1'b1;
                wr_addr = base_q + ADDR_WIDTH'(2);
                wr_data = DATA_WIDTH'({name_q[4], name_q[5], name_q[6], name_q[7]});
                state_d = StHdr;
            end
            StHdr: begin
                wr_en   = 1'b1;
                wr_data = DATA_WIDTH'({rows_q, cols_q});
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Abort outranks every write, including a coincident element or header commit.
        if (bus.abort && (state_q != StIdle)) begin
            state_d = StIdle;
            wr_en   = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            id_q    <= '0;
            rows_q  <= '0;
            cols_q  <= '0;
            name_q  <= '{default: '0};
            base_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            name_q  <= name_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.write_ready  = (state_q == StIdle);
    assign bus.writer_ready = (state_q == StData);
    assign bus.write_done   = (state_q == StDone);
    assign bus.write_error  = err_q;
    assign bus.mem_wr_en    = wr_en && !rst;
    assign bus.mem_wr_addr  = wr_addr;
    assign bus.mem_wr_data  = wr_data;
endmodule

// File: tb/tb_matrix_writer.sv
// Scoreboard bench for matrix_writer: a slot-level model queues the expected RAM
// writes and pulses; an independent monitor pops and compares them.
module tb_matrix_writer;
    localparam int BlockSize = 1152;
    localparam int NumSlots  = 8;

    typedef enum int {KWr, KDone, KErr} kind_e;
    typedef struct {
        kind_e       kind;
        int unsigned addr;
        int unsigned data;
        int          gap;   // required cycles since previous event, 0 = any
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   last_cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    exp_t        sb [$];
    int unsigned shadow  [int];
    int unsigned ref_mem [int];

    matrix_writer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(14)) bus ();

    matrix_writer #(
        .BLOCK_SIZE(BlockSize),
        .NUM_SLOTS (NumSlots),
        .DATA_WIDTH(32),
        .ADDR_WIDTH(14)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_take(input kind_e k, input int unsigned a, input int unsigned d);
        exp_t e;
        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $display("FAIL sb_unexpected: got kind=%0d addr=%0d data=%0h, expected no event",
                     k, a, d);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || (k == KWr && (e.addr != a || e.data != d)) ||
                (e.gap != 0 && cyc - last_cyc != e.gap)) begin
                mismatched++;
                $display("FAIL sb_event: got kind=%0d addr=%0d data=%0h gap=%0d, expected kind=%0d addr=%0d data=%0h gap=%0d",
                         k, a, d, cyc - last_cyc, e.kind, e.addr, e.data, e.gap);
            end
        end
        last_cyc = cyc;
        if (k == KWr) shadow[int'(a)] = d;
    endtask

    // Monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (bus.mem_wr_en)   sb_take(KWr, 32'(bus.mem_wr_addr), bus.mem_wr_data);
        if (bus.write_done)  sb_take(KDone, 0, 0);
        if (bus.write_error) sb_take(KErr, 0, 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input kind_e k, input int unsigned a, input int unsigned d,
                        input int gap);
        exp_t e;
        e.kind = k; e.addr = a; e.data = d; e.gap = gap;
        sb.push_back(e);
        if (k == KWr) ref_mem[int'(a)] = d;
    endtask

    task automatic wait_writer_ready();
        int n = 0;
        while (!bus.writer_ready && n < 100) begin step(); n++; end
        if (!bus.writer_ready) check("writer_ready_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin step(); n++; end
        check("sb_drain_left", sb.size(), 0);
    endtask

    // mode: 0 normal, 1 abort after stop_after elements, 2 reset after stop_after elements.
    // req_mid drives a stray write_request during DATA; extra drives data_valid after the end.
    task automatic run_txn(input int id, input int r, input int c, input logic [63:0] nm,
                           input int mode, input int stop_after, input bit req_mid,
                           input bit extra, input int max_gap);
        int          n    = r * c;
        int          base = id * BlockSize;
        bit          bad  = (r == 0) || (c == 0) || (id >= NumSlots) || (n > BlockSize - 3);
        int          nel;
        int unsigned d [$];
        for (int k = 0; k < n; k++) d.push_back($urandom);
        nel = (mode == 0) ? n : stop_after;

        if (bad) begin
            push(KErr, 0, 0, 0);
        end else begin
            push(KWr, base, 0, 0);
            for (int k = 0; k < nel; k++) push(KWr, base + 3 + k, d[k], 0);
            if (mode == 0) begin
                push(KWr, base + 1, nm[63:32], 1);
                push(KWr, base + 2, nm[31:0], 1);
                push(KWr, base, {16'd0, r[7:0], c[7:0]}, 1);
                push(KDone, 0, 0, 1);
            end
        end

        begin
            int w = 0;
            while (!bus.write_ready && w < 100) begin step(); w++; end
            check("write_ready_before_req", bus.write_ready, 1);
        end
        bus.matrix_id   = id[2:0];
        bus.actual_rows = r[7:0];
        bus.actual_cols = c[7:0];
        for (int i = 0; i < 8; i++) bus.matrix_name[i] = nm[63 - 8 * i -: 8];
        bus.write_request = 1'b1;
        step();
        bus.write_request = 1'b0;
        bus.matrix_id     = 3'($urandom);
        bus.actual_rows   = 8'($urandom);

        if (bad) begin
            check("reject_ready_low", bus.write_ready, 0);
            step();
            check("reject_ready_back", bus.write_ready, 1);
            check("reject_error_pulse", bus.write_error, 1);
            wait_drain();
            return;
        end

        for (int k = 0; k < nel; k++) begin
            wait_writer_ready();
            bus.data_valid = 1'b1;
            bus.data_in    = d[k];
            if (req_mid && k == 0) begin
                bus.write_request = 1'b1;
                bus.matrix_id     = 3'(id + 1);
            end
            step();
            bus.data_valid    = 1'b0;
            bus.write_request = 1'b0;
            bus.data_in       = $urandom;
            if (k != nel - 1) repeat ($urandom_range(0, max_gap)) step();
        end

        if (mode == 1) begin
            check("abort_still_in_data", bus.writer_ready, 1);
            bus.abort      = 1'b1;
            bus.data_valid = 1'b1;
            step();
            bus.abort      = 1'b0;
            bus.data_valid = 1'b0;
            check("abort_ready_next", bus.write_ready, 1);
        end else if (mode == 2) begin
            rst            = 1'b1;
            bus.data_valid = 1'b1;
            step();
            rst            = 1'b0;
            bus.data_valid = 1'b0;
            check("rst_write_ready", bus.write_ready, 1);
            check("rst_writer_ready", bus.writer_ready, 0);
            check("rst_mem_wr_en", bus.mem_wr_en, 0);
            check("rst_write_done", bus.write_done, 0);
            check("rst_write_error", bus.write_error, 0);
        end else if (extra) begin
            bus.data_valid = 1'b1;
            repeat (3) step();
            bus.data_valid = 1'b0;
        end
        repeat (6) step();
        wait_drain();
    endtask

    initial begin
        bus.write_request = 1'b0;
        bus.matrix_id     = '0;
        bus.actual_rows   = '0;
        bus.actual_cols   = '0;
        for (int i = 0; i < 8; i++) bus.matrix_name[i] = '0;
        bus.data_in       = '0;
        bus.data_valid    = 1'b0;
        bus.abort         = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        check("reset_write_ready", bus.write_ready, 1);
        check("reset_writer_ready", bus.writer_ready, 0);
        check("reset_write_done", bus.write_done, 0);
        check("reset_write_error", bus.write_error, 0);
        check("reset_mem_wr_en", bus.mem_wr_en, 0);

        // Abort in IDLE is ignored.
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("idle_abort_ready", bus.write_ready, 1);

        // Basic 2x2 "MAT_A" with gaps, plus trailing data_valid that must be ignored.
        run_txn(1, 2, 2, 64'h4D41545F_41000000, 0, 0, 1'b0, 1'b1, 1);
        check("basic_word0", shadow.exists(1152) ? shadow[1152] : 32'hDEAD, 32'h00000202);
        check("basic_word1", shadow.exists(1153) ? shadow[1153] : 32'hDEAD, 32'h4D41545F);
        check("basic_word2", shadow.exists(1154) ? shadow[1154] : 32'hDEAD, 32'h41000000);

        // Rejected descriptors.
        run_txn(3, 0, 3, 64'h0, 0, 0, 1'b0, 1'b0, 0);
        run_txn(4, 34, 34, 64'h0, 0, 0, 1'b0, 1'b0, 0);
        run_txn(5, 4, 0, 64'h0, 0, 0, 1'b0, 1'b0, 0);

        // Largest accepted matrix in the last slot.
        run_txn(7, 33, 33, 64'h4249475F_4D415458, 0, 0, 1'b0, 1'b0, 1);
        check("max_last_elem_written", shadow.exists(9155), 1);

        // Fill slot 2, then abort a rewrite of it after 5 elements.
        run_txn(2, 1, 2, 64'h4F4C445F_53524300, 0, 0, 1'b0, 1'b0, 0);
        run_txn(2, 3, 3, 64'h41424F52_54000000, 1, 5, 1'b0, 1'b0, 2);
        check("abort_word0_zero", shadow.exists(2304) ? shadow[2304] : 32'hDEAD, 0);
        run_txn(2, 1, 1, 64'h4F4E4500_00000000, 0, 0, 1'b0, 1'b0, 0);
        check("after_abort_word0", shadow.exists(2304) ? shadow[2304] : 32'hDEAD, 32'h101);

        // Stray write_request during DATA, then reset mid-write.
        run_txn(0, 2, 3, 64'h53545241_59000000, 0, 0, 1'b1, 1'b0, 1);
        run_txn(3, 2, 2, 64'h52535400_00000000, 2, 1, 1'b0, 1'b0, 0);

        // Randomized descriptors.
        for (int t = 0; t < 10; t++) begin
            int sel = $urandom_range(0, 5);
            int id  = $urandom_range(0, 7);
            int r   = $urandom_range(1, 6);
            int c   = $urandom_range(1, 6);
            logic [63:0] nm = {$urandom, $urandom};
            if (sel == 0) r = 0;
            if (sel == 1) begin r = $urandom_range(34, 255); c = $urandom_range(34, 255); end
            run_txn(id, r, c, nm, 0, 0, 1'b0, sel[0], 2);
        end

        foreach (ref_mem[a]) begin
            compared++;
            if (!shadow.exists(a) || shadow[a] != ref_mem[a]) begin
                mismatched++;
                $display("FAIL mem_image at %0d: got %0h expected %0h", a,
                         shadow.exists(a) ? shadow[a] : 32'hDEAD, ref_mem[a]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
